pixel_display_controller: RTL
=============================

# pixel_display_controller

Memory-mapped display controller on the CPU data-memory bus in the I/O region selected by address bits [63:56]. It decodes LDUR/STUR accesses to a command register, a status register and a 600-word pixel frame buffer. A scanout engine streams the frame buffer as 16-bit pixels over a valid/ready interface to the display sink. Pixel test programs depend on it: they poll STATUS, fill the buffer, then write CMD.

## Interface
- BASE_TAG, 8'h02: value of address[63:56] that selects this block.
- FB_OFFSET, 604: word offset of frame-buffer entry 0.
- FB_WORDS, 600: frame-buffer depth in 64-bit words, 4 pixels per word.
- ROW_WORDS, 15: words per display row, giving 60 pixels × 40 rows.
- clock  in  1  system clock. All state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_address  in  64  CPU data address, in word units.
- mem_write_data  in  64  CPU store data.
- mem_write  in  1  store strobe, one cycle per STUR.
- mem_read  in  1  load strobe.
- mem_read_data  out  64  load data, combinational. Zero when the address is not selected.
- pix_data  out  16  current pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  sink accepts the pixel.
- pix_sof  out  1  first pixel of the frame. Qualified by pix_valid.
- pix_eol  out  1  last pixel of a row. Qualified by pix_valid.
- pix_eof  out  1  last pixel of the frame. Qualified by pix_valid.

## Operation
- **Select:** sel = (mem_address[63:56] == BASE_TAG). Offset = mem_address[15:0]. Offsets other than those below: writes are ignored, reads return 0.
- **Offset 0, CMD (write-only):**
  - bit0 GO: start scanout.
  - bit1 CLEAR: zero the frame buffer.
  - bit2 ONESHOT: one frame only, then return to IDLE. Otherwise frames repeat continuously.
  - bit3 STOP: clear the continuous flag. Scanout finishes the current frame, then goes IDLE.
  - Any CMD write clears OVERRUN.
  - GO and CLEAR are ignored unless state is IDLE.
  - GO and CLEAR together: CLEAR runs first, then scanout starts automatically.
- **Offset 2, STATUS (read-only):**
  - bit0 READY: state is IDLE.
  - bit1 LINK_UP: sticky. Set the first cycle pix_ready is seen high after reset.
  - bit2 OVERRUN: sticky. Set by a frame-buffer write while not READY.
  - bits 63:3 read as 0.
- **Offsets FB_OFFSET..FB_OFFSET+FB_WORDS-1, frame buffer (write-only):**
  - Writes go to word (offset − FB_OFFSET) only when READY. Otherwise the write is dropped and OVERRUN is set.
  - Reads return 0.
- **Pixel order in a word:** pixel 0 = bits[63:48], then [47:32], [31:16], [15:0].
- **FSM states:**
  - IDLE: leave on GO (to FETCH) or on CLEAR (to CLEAR).
  - CLEAR: write 0 to word clr_cnt, clr_cnt from 0 to 599. After word 599, go to FETCH if GO was pending, else IDLE.
  - FETCH: issue a RAM read of word_cnt. Always go to STREAM next cycle, loading the word register.
  - STREAM: pix_valid = 1. On pix_valid && pix_ready, increment pix_idx.
    - pix_idx == 3: advance word_cnt and go to FETCH.
    - Last word of the frame: word_cnt, row and col wrap to 0. If continuous, go to FETCH; else go to IDLE.
- **Counters:**
  - word_cnt: 10 bits, 0..599.
  - col: 0..14.
  - row: 0..39.
  - pix_idx: 2 bits.
- **Flags:**
  - pix_sof = (word_cnt == 0 && pix_idx == 0).
  - pix_eol = (col == 14 && pix_idx == 3).
  - pix_eof = (word_cnt == 599 && pix_idx == 3).
- **Backpressure:** pix_data and the flags hold stable while pix_valid && !pix_ready.
- **Reset:**
  - State IDLE, all counters 0, continuous flag 0, pending GO 0, LINK_UP 0, OVERRUN 0.
  - pix_valid = 0. pix_data and all flags = 0.
  - Frame-buffer contents are not reset.
  - Reset mid-frame or mid-clear aborts immediately, with no further RAM writes.

## Timing
- STATUS reads are combinational in the same cycle, as required by the single-cycle CPU.
- A CMD write with GO sampled at edge k moves the state to FETCH. pix_valid first rises after edge k+1.
- READY falls in the cycle after the CMD write edge.
- Maximum throughput is 4 pixels per 5 cycles, because of one FETCH bubble per word.
- One frame takes at least 3000 cycles.
- CLEAR takes 600 cycles. READY returns the cycle after the write to word 599, unless GO is pending.
- Frame-buffer RAM: one write port, used by the CPU when IDLE and by CLEAR otherwise. One synchronous read port with 1-cycle latency, used by scanout.

## Structure
- Package display_pkg holds:
  - offset constants CMD_OFF = 0, STATUS_OFF = 2, FB_OFFSET = 604, FB_WORDS = 600;
  - CMD bit indices;
  - STATUS bit indices;
  - the FSM state enum {IDLE, CLEAR, FETCH, STREAM}.
- Sub-module frame_buffer_ram: 600×64 simple dual-port RAM with registered read.
- Bus decode, FSM and counters live in pixel_display_controller.

## Test plan
- **Reset and link:**
  - Stimulus: after reset, read base+2. Then drive pix_ready = 1 for one cycle and read base+2 again.
  - Response: first read returns 0x1. Second read returns 0x3.
- **Fill and one-shot frame:**
  - Stimulus: write 0xC0300CF03CCC54FC to all 600 words, then write CMD = 5. Hold pix_ready high.
  - Response: exactly 2400 pixels in the sequence C030, 0CF0, 3CCC, 54FC, repeating.
  - Flags: pix_sof on pixel 0. pix_eol on every 60th pixel. pix_eof on pixel 2399.
  - READY returns afterwards.
- **Backpressure:**
  - Stimulus: pix_ready held low for 10 cycles mid-word.
  - Response: pix_data and flags stay stable. No pixel is lost or duplicated.
- **Overrun:**
  - Stimulus: a frame-buffer write during STREAM.
  - Response: STATUS = 0x6 and the RAM is unchanged. A later CMD write clears bit2.
- **CLEAR+GO:**
  - Stimulus: write CMD = 0x7 after a nonzero fill.
  - Response: READY low for 600+ cycles, then 2400 zero pixels, then IDLE.
- **Continuous, STOP and reset:**
  - Stimulus: write CMD = 1, then CMD = 8 mid-frame.
  - Response: the current frame completes through pix_eof, then IDLE. A second run with reset mid-frame gives pix_valid = 0 and STATUS = 0x1 on the next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, register bit positions and FSM state type for the
// memory-mapped pixel display controller.
package display_pkg;

  localparam logic [7:0]  BASE_TAG   = 8'h02;
  localparam logic [15:0] CMD_OFF    = 16'd0;
  localparam logic [15:0] STATUS_OFF = 16'd2;
  localparam logic [15:0] FB_OFFSET  = 16'd604;
  localparam logic [15:0] FB_WORDS   = 16'd600;
  localparam int unsigned FB_DEPTH   = 600;
  localparam int unsigned ROW_WORDS  = 15;

  localparam logic [9:0] LAST_WORD = 10'(FB_DEPTH - 1);
  localparam logic [3:0] LAST_COL  = 4'(ROW_WORDS - 1);
  localparam logic [5:0] LAST_ROW  = 6'((FB_DEPTH / ROW_WORDS) - 1);

  localparam int unsigned CMD_GO      = 0;
  localparam int unsigned CMD_CLEAR   = 1;
  localparam int unsigned CMD_ONESHOT = 2;
  localparam int unsigned CMD_STOP    = 3;

  localparam int unsigned ST_READY   = 0;
  localparam int unsigned ST_LINK_UP = 1;
  localparam int unsigned ST_OVERRUN = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FETCH,
    STREAM
  } state_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// 600x64 simple dual-port frame buffer: one write port, one registered read port.
module frame_buffer_ram
  import display_pkg::*;
(
  input  logic        clock,
  input  logic        we,
  input  logic [9:0]  waddr,
  input  logic [63:0] wdata,
  input  logic        re,
  input  logic [9:0]  raddr,
  output logic [63:0] rdata
);

  logic [63:0] mem_q [FB_DEPTH];
  logic [63:0] rdata_q;

  // Read data holds between reads so it doubles as the scanout word register.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pixel_display_controller.sv
// Bus-mapped display controller: CMD/STATUS registers, frame-buffer writes,
// and a scanout engine streaming 16-bit pixels over valid/ready.
module pixel_display_controller
  import display_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] mem_address,
  input  logic [63:0] mem_write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [63:0] mem_read_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof
);

  state_e      state_q, state_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;
  logic [9:0]  word_cnt_q, word_cnt_d;
  logic [3:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [1:0]  pix_idx_q, pix_idx_d;
  logic        cont_q, cont_d;
  logic        go_pend_q, go_pend_d;
  logic        link_q, link_d;
  logic        ovr_q, ovr_d;

  logic        sel;
  logic [15:0] off;
  logic [15:0] fb_rel;
  logic        cmd_wr;
  logic        fb_hit;
  logic        fb_wr;
  logic        ready;
  logic        ram_we;
  logic        ram_re;
  logic [9:0]  ram_waddr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;
  logic [15:0] cur_pix;
  logic        unused_bits;

  assign sel         = (mem_address[63:56] == BASE_TAG);
  assign off         = mem_address[15:0];
  assign fb_rel      = off - FB_OFFSET;
  assign unused_bits = ^{mem_address[55:16], fb_rel[15:10]};
  assign cmd_wr      = sel && mem_write && (off == CMD_OFF);
  assign fb_hit      = sel && (off >= FB_OFFSET) && (off < FB_OFFSET + FB_WORDS);
  assign fb_wr       = fb_hit && mem_write;
  assign ready       = (state_q == IDLE);

  frame_buffer_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (word_cnt_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    word_cnt_d = word_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    pix_idx_d  = pix_idx_q;
    cont_d     = cont_q;
    go_pend_d  = go_pend_q;
    link_d     = link_q | pix_ready;
    ovr_d      = ovr_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = fb_rel[9:0];
    ram_wdata  = mem_write_data;

    if (cmd_wr) ovr_d = 1'b0;
    if (fb_wr && !ready) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        ram_we = fb_wr;
        if (cmd_wr) begin
          if (mem_write_data[CMD_GO]) cont_d = !mem_write_data[CMD_ONESHOT];
          if (mem_write_data[CMD_CLEAR]) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            go_pend_d = mem_write_data[CMD_GO];
          end else if (mem_write_data[CMD_GO]) begin
            state_d = FETCH;
          end
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        if (clr_cnt_q == LAST_WORD) begin
          clr_cnt_d = '0;
          go_pend_d = 1'b0;
          state_d   = go_pend_q ? FETCH : IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end
      FETCH: begin
        ram_re  = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (pix_ready) begin
          pix_idx_d = pix_idx_q + 2'd1;
          if (pix_idx_q == 2'd3) begin
            state_d = FETCH;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = (row_q == LAST_ROW) ? '0 : row_q + 6'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              row_d      = '0;
              col_d      = '0;
              if (!cont_q) state_d = IDLE;
            end else begin
              word_cnt_d = word_cnt_q + 10'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // STOP applies after GO so a combined GO|STOP behaves as one-shot.
    if (cmd_wr && mem_write_data[CMD_STOP]) cont_d = 1'b0;

    // The reset edge itself must not commit a frame-buffer write.
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      word_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pix_idx_q  <= '0;
      cont_q     <= 1'b0;
      go_pend_q  <= 1'b0;
      link_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      word_cnt_q <= word_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pix_idx_q  <= pix_idx_d;
      cont_q     <= cont_d;
      go_pend_q  <= go_pend_d;
      link_q     <= link_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    unique case (pix_idx_q)
      2'd0:    cur_pix = ram_rdata[63:48];
      2'd1:    cur_pix = ram_rdata[47:32];
      2'd2:    cur_pix = ram_rdata[31:16];
      default: cur_pix = ram_rdata[15:0];
    endcase
  end

  assign pix_valid = (state_q == STREAM);
  assign pix_data  = pix_valid ? cur_pix : '0;
  assign pix_sof   = pix_valid && (word_cnt_q == '0) && (pix_idx_q == 2'd0);
  assign pix_eol   = pix_valid && (col_q == LAST_COL) && (pix_idx_q == 2'd3);
  assign pix_eof   = pix_valid && (word_cnt_q == LAST_WORD) && (pix_idx_q == 2'd3);

  always_comb begin
    mem_read_data = '0;
    if (sel && mem_read && (off == STATUS_OFF)) begin
      mem_read_data[ST_READY]   = ready;
      mem_read_data[ST_LINK_UP] = link_q;
      mem_read_data[ST_OVERRUN] = ovr_q;
    end
  end

endmodule
